fp_normalize_pack: RTL and testbench
====================================

FP_NORMALIZE_PACK -- requirements
Module: fp_normalize_pack

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: raw-sum operands valid.
REQ-004 SHALL have port in_ready, output, 1 bit: high only in IDLE.
REQ-005 SHALL have port SO, input, 1 bit: result sign from adder stage.
REQ-006 SHALL have port CO, input, 1 bit: adder carry-out.
REQ-007 SHALL have port S, input, 28 bits: sum magnitude; hidden bit at S[26], fraction S[25:3], guard/round/sticky S[2:0].
REQ-008 SHALL have port EXP, input, 8 bits: common (larger) biased exponent.
REQ-009 SHALL have port out_valid, output, 1 bit: RESULT valid, held until taken.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts RESULT.
REQ-011 SHALL have port RESULT, output, 32 bits: packed IEEE754 single.
REQ-012 SHALL have port OVF, output, 1 bit: overflow to infinity, valid with out_valid.
REQ-013 SHALL have port UNF, output, 1 bit: subnormal or zero result from nonzero input, valid with out_valid.

Function
REQ-014 SHALL implement states IDLE, NORM, ROUND and DONE.
REQ-015 IDLE: on in_valid && in_ready, SHALL capture M={CO,S} (29 bits), E=EXP zero-extended to 10 bits, and sign, then go to NORM.
REQ-016 NORM, per cycle: if M==0, SHALL go to DONE and produce +0 (RESULT=32'h0, UNF=0).
REQ-017 NORM: if M[28] or M[27] is set, SHALL shift M right 1, OR the shifted-out bit into M[0] (sticky), and set E+=1.
REQ-018 NORM: if M[28:26]==0 and E>1, SHALL shift M left 1 and set E-=1.
REQ-019 NORM: if M[28:27]==0 and (M[26]==1 or E==1), SHALL go to ROUND; exactly one shift per cycle.
REQ-020 ROUND SHALL apply round-to-nearest-even: increment M[26:3] if M[2] && (M[1]|M[0]|M[3]).
REQ-021 ROUND: if the increment carries into bit 27, SHALL shift right 1 and set E+=1; then go to DONE.
REQ-022 Pack: if E>=255, SHALL output RESULT={sign,8'hFF,23'h0} and OVF=1.
REQ-023 Pack: else if M[26]==0, SHALL output exponent field 0 (subnormal) and UNF=1.
REQ-024 Pack: else SHALL output RESULT={sign,E[7:0],M[25:3]}.
REQ-025 DONE: out_valid SHALL be 1; on out_ready, go to IDLE; RESULT, OVF and UNF SHALL be stable while out_valid && !out_ready.
REQ-026 Latency: with n NORM shifts, out_valid SHALL rise n+2 clock edges after the accepting edge (n+1 without rounding); no pipelining, one operation in flight.
REQ-027 in_valid SHALL be ignored outside IDLE; there SHALL be no combinational path from in_valid to in_ready or from out_ready to out_valid.

Reset
REQ-028 On rst: state=IDLE, in_ready=1, out_valid=0, RESULT=32'h0, OVF=0, UNF=0, and internal M/E cleared.
REQ-029 rst asserted mid-operation SHALL abort it with no output produced; rst SHALL take priority over all handshakes.

Configuration
REQ-030 Macro FPNP_ROUND_EN defined: ROUND state present per REQ-020/021.
REQ-031 Macro FPNP_ROUND_EN undefined: NORM SHALL go directly to DONE, M[2:0] SHALL be truncated, and latency SHALL be reduced by one cycle.

Verification
REQ-032 1.0+1.0: CO=0, S=28'h8000000, EXP=127, SO=0 -> RESULT=32'h40000000, out_valid 3 edges after accept (EN).
REQ-033 Cancellation: S=28'h0000008, EXP=127, SO=1 -> 23 left shifts, RESULT=32'hB4000000, out_valid 25 edges after accept.
REQ-034 Exact zero: CO=0, S=0, EXP=100 -> RESULT=32'h00000000, UNF=0, OVF=0.
REQ-035 Overflow: CO=1, S=0, EXP=254 -> RESULT=32'h7F800000, OVF=1; rounding tie S=28'h400000C, EXP=127 -> RESULT=32'h3F800002 with EN, 32'h3F800001 without.
REQ-036 Backpressure and reset: hold out_ready=0 for 5 cycles -> RESULT stable, in_ready=0; assert rst in NORM -> next cycle in_ready=1, out_valid=0.

Source files
------------

// File: rtl/fp_normalize_pack_if.sv
// Handshake and data bundle between the adder stage, fp_normalize_pack and its consumer.
// The adder side drives the raw sum; the consumer side takes the packed single-precision result.
interface fp_normalize_pack_if;
    logic        in_valid;
    logic        in_ready;
    logic        SO;
    logic        CO;
    logic [27:0] S;
    logic [7:0]  EXP;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] RESULT;
    logic        OVF;
    logic        UNF;

    modport master (
        output in_valid, SO, CO, S, EXP, out_ready,
        input  in_ready, out_valid, RESULT, OVF, UNF
    );

    modport slave (
        input  in_valid, SO, CO, S, EXP, out_ready,
        output in_ready, out_valid, RESULT, OVF, UNF
    );
endinterface

// File: rtl/fp_normalize_pack.sv
// Normalizes a raw adder sum one bit per cycle, optionally rounds, and packs an IEEE754 single.
// Define FPNP_ROUND_EN to enable the round-to-nearest-even ROUND state; otherwise GRS bits are truncated.
module fp_normalize_pack (
    input logic                clk,
    input logic                rst,
    fp_normalize_pack_if.slave bus
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t      state;
    logic [28:0] m;
    logic [9:0]  e;
    logic        sign;
    logic        in_ready_r;
    logic        out_valid_r;
    logic [31:0] result_r;
    logic        ovf_r;
    logic        unf_r;

    // Returns {RESULT, OVF, UNF}; mant holds the hidden bit at [23] and the fraction below it.
    function automatic logic [33:0] pack_result(input logic s, input logic [9:0] ex,
                                                input logic [23:0] mant);
        if (ex >= 10'd255) begin
            return {s, 8'hFF, 23'h0, 1'b1, 1'b0};
        end else if (!mant[23]) begin
            return {s, 8'h00, mant[22:0], 1'b0, 1'b1};
        end else begin
            return {s, ex[7:0], mant[22:0], 2'b00};
        end
    endfunction

`ifdef FPNP_ROUND_EN
    logic        round_up;
    logic [24:0] rnd_sum;
    logic [23:0] rnd_mant;
    logic [9:0]  rnd_exp;

    // A carry out of the 24-bit mantissa renormalizes by one right shift.
    always_comb begin
        round_up = m[2] & (m[1] | m[0] | m[3]);
        rnd_sum  = {1'b0, m[26:3]} + {24'd0, round_up};
        if (rnd_sum[24]) begin
            rnd_mant = rnd_sum[24:1];
            rnd_exp  = e + 10'd1;
        end else begin
            rnd_mant = rnd_sum[23:0];
            rnd_exp  = e;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            m           <= '0;
            e           <= '0;
            sign        <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        m          <= {bus.CO, bus.S};
                        e          <= {2'b00, bus.EXP};
                        sign       <= bus.SO;
                        in_ready_r <= 1'b0;
                        state      <= NORM;
                    end
                end
                NORM: begin
                    if (m == '0) begin
                        result_r    <= '0;
                        ovf_r       <= 1'b0;
                        unf_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else if (m[28] || m[27]) begin
                        m <= {1'b0, m[28:2], m[1] | m[0]};
                        e <= e + 10'd1;
                    end else if (!m[26] && e > 10'd1) begin
                        m <= {m[27:0], 1'b0};
                        e <= e - 10'd1;
                    end else begin
                        // Stops on the hidden bit, or at the smallest exponent (subnormal result).
`ifdef FPNP_ROUND_EN
                        state <= ROUND;
`else
                        {result_r, ovf_r, unf_r} <= pack_result(sign, e, m[26:3]);
                        out_valid_r              <= 1'b1;
                        state                    <= DONE;
`endif
                    end
                end
`ifdef FPNP_ROUND_EN
                ROUND: begin
                    m                        <= {2'b00, rnd_mant, 3'b000};
                    e                        <= rnd_exp;
                    {result_r, ovf_r, unf_r} <= pack_result(sign, rnd_exp, rnd_mant);
                    out_valid_r              <= 1'b1;
                    state                    <= DONE;
                end
`endif
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.RESULT    = result_r;
    assign bus.OVF       = ovf_r;
    assign bus.UNF       = unf_r;
endmodule

// File: tb/tb_fp_normalize_pack.sv
// Scoreboard bench for fp_normalize_pack: expectations queued at stimulus, popped at output.
// Expected values follow FPNP_ROUND_EN so the same bench covers both builds.
module tb_fp_normalize_pack;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fp_normalize_pack_if bus();

    fp_normalize_pack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef FPNP_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    typedef struct {
        logic        so;
        logic        co;
        logic [27:0] s;
        logic [7:0]  exp;
        logic [31:0] r_en;
        logic [31:0] r_no;
        logic        ovf;
        logic        unf;
        int          lat_en;
        int          lat_no;
    } vec_t;

    typedef struct {
        logic [31:0] result;
        logic        ovf;
        logic        unf;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    function automatic vec_t mk(input logic so, input logic co, input logic [27:0] s,
                                input logic [7:0] exp, input logic [31:0] r_en,
                                input logic [31:0] r_no, input logic ovf, input logic unf,
                                input int lat_en, input int lat_no);
        vec_t v;
        v.so = so; v.co = co; v.s = s; v.exp = exp;
        v.r_en = r_en; v.r_no = r_no; v.ovf = ovf; v.unf = unf;
        v.lat_en = lat_en; v.lat_no = lat_no;
        return v;
    endfunction

    function automatic exp_t expect_of(input vec_t v);
        exp_t x;
        x.result = ROUND_EN ? v.r_en : v.r_no;
        x.ovf    = v.ovf;
        x.unf    = v.unf;
        x.lat    = ROUND_EN ? v.lat_en : v.lat_no;
        return x;
    endfunction

    // Drives one operand set, then counts edges after the accepting edge until out_valid.
    task automatic run_op(input vec_t v, output logic [31:0] res, output logic ovf,
                          output logic unf, output int lat);
        @(posedge clk); #1;
        bus.SO       = v.so;
        bus.CO       = v.co;
        bus.S        = v.s;
        bus.EXP      = v.exp;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.RESULT;
        ovf = bus.OVF;
        unf = bus.UNF;
    endtask

    task automatic drain();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.SO        = 1'b0;
        bus.CO        = 1'b0;
        bus.S         = '0;
        bus.EXP       = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset in_ready: got %b want 1", bus.in_ready); else passes++;
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset out_valid: got %b want 0", bus.out_valid); else passes++;
        checks++; if (bus.RESULT !== 32'h0) $display("[TB] FAIL reset RESULT: got %h want 00000000", bus.RESULT); else passes++;
        checks++; if (bus.OVF !== 1'b0) $display("[TB] FAIL reset OVF: got %b want 0", bus.OVF); else passes++;
        checks++; if (bus.UNF !== 1'b0) $display("[TB] FAIL reset UNF: got %b want 0", bus.UNF); else passes++;
    endtask

    task automatic test_vectors();
        vec_t        vt[$];
        exp_t        x;
        logic [31:0] res;
        logic        ovf, unf;
        int          lat;
        vt.push_back(mk(0, 0, 28'h8000000, 8'd127, 32'h40000000, 32'h40000000, 0, 0, 3, 2));
        vt.push_back(mk(1, 0, 28'h0000008, 8'd127, 32'hB4000000, 32'hB4000000, 0, 0, 25, 24));
        vt.push_back(mk(0, 0, 28'h0000000, 8'd100, 32'h00000000, 32'h00000000, 0, 0, 1, 1));
        vt.push_back(mk(0, 1, 28'h0000000, 8'd254, 32'h7F800000, 32'h7F800000, 1, 0, 4, 3));
        vt.push_back(mk(0, 0, 28'h400000C, 8'd127, 32'h3F800002, 32'h3F800001, 0, 0, 2, 1));
        vt.push_back(mk(0, 0, 28'h0000008, 8'd10,  32'h00000200, 32'h00000200, 0, 1, 11, 10));
        vt.push_back(mk(0, 0, 28'h7FFFFFC, 8'd127, 32'h40000000, 32'h3FFFFFFF, 0, 0, 2, 1));
        vt.push_back(mk(0, 0, 28'h4000004, 8'd127, 32'h3F800000, 32'h3F800000, 0, 0, 2, 1));
        vt.push_back(mk(0, 0, 28'h8000009, 8'd127, 32'h40000001, 32'h40000000, 0, 0, 3, 2));
        bus.out_ready = 1'b1;
        foreach (vt[i]) begin
            sb.push_back(expect_of(vt[i]));
            run_op(vt[i], res, ovf, unf, lat);
            x = sb.pop_front();
            checks++; if (res !== x.result) $display("[TB] FAIL vec%0d RESULT: got %h want %h", i, res, x.result); else passes++;
            checks++; if (ovf !== x.ovf) $display("[TB] FAIL vec%0d OVF: got %b want %b", i, ovf, x.ovf); else passes++;
            checks++; if (unf !== x.unf) $display("[TB] FAIL vec%0d UNF: got %b want %b", i, unf, x.unf); else passes++;
            checks++; if (lat !== x.lat) $display("[TB] FAIL vec%0d latency: got %0d want %0d", i, lat, x.lat); else passes++;
            drain();
        end
    endtask

    task automatic test_reset_abort();
        logic seen;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.SO = 1'b1; bus.CO = 1'b0; bus.S = 28'h0000008; bus.EXP = 8'd127;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL abort busy in_ready: got %b want 0", bus.in_ready); else passes++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL abort in_ready: got %b want 1", bus.in_ready); else passes++;
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL abort out_valid: got %b want 0", bus.out_valid); else passes++;
        checks++; if (bus.RESULT !== 32'h0) $display("[TB] FAIL abort RESULT: got %h want 00000000", bus.RESULT); else passes++;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) $display("[TB] FAIL abort no_output: got %b want 0", seen); else passes++;
    endtask

    task automatic test_backpressure();
        vec_t        v;
        exp_t        x;
        logic [31:0] res;
        logic        ovf, unf;
        int          lat;
        v = mk(0, 0, 28'h400000C, 8'd127, 32'h3F800002, 32'h3F800001, 0, 0, 2, 1);
        bus.out_ready = 1'b0;
        sb.push_back(expect_of(v));
        run_op(v, res, ovf, unf, lat);
        x = sb.pop_front();
        checks++; if (res !== x.result) $display("[TB] FAIL bp RESULT: got %h want %h", res, x.result); else passes++;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if (bus.RESULT !== x.result) $display("[TB] FAIL bp hold%0d RESULT: got %h want %h", c, bus.RESULT, x.result); else passes++;
            checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL bp hold%0d out_valid: got %b want 1", c, bus.out_valid); else passes++;
            checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL bp hold%0d in_ready: got %b want 0", c, bus.in_ready); else passes++;
        end
        bus.out_ready = 1'b1;
        drain();
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL bp release out_valid: got %b want 0", bus.out_valid); else passes++;
        checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL bp release in_ready: got %b want 1", bus.in_ready); else passes++;
    endtask

    // Raises in_valid with other operands while the unit is busy; they must not be captured.
    task automatic test_ignore_busy();
        vec_t        v;
        exp_t        x;
        logic [31:0] res;
        logic        ovf, unf, seen;
        int          lat;
        v = mk(0, 0, 28'h8000000, 8'd127, 32'h40000000, 32'h40000000, 0, 0, 3, 2);
        bus.out_ready = 1'b1;
        sb.push_back(expect_of(v));
        fork
            run_op(v, res, ovf, unf, lat);
            begin
                @(posedge clk);
                @(posedge clk);
                #2;
                bus.SO = 1'b1; bus.S = 28'h0000008; bus.EXP = 8'd50;
                bus.in_valid = 1'b1;
                @(posedge clk);
                @(posedge clk);
                #2 bus.in_valid = 1'b0;
            end
        join
        x = sb.pop_front();
        checks++; if (res !== x.result) $display("[TB] FAIL busy RESULT: got %h want %h", res, x.result); else passes++;
        checks++; if (lat !== x.lat) $display("[TB] FAIL busy latency: got %0d want %0d", lat, x.lat); else passes++;
        drain();
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1 || bus.in_ready !== 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) $display("[TB] FAIL busy spurious_capture: got %b want 0", seen); else passes++;
    endtask

    task automatic test_back_to_back();
        vec_t        va, vb;
        exp_t        x;
        logic [31:0] res;
        logic        ovf, unf;
        int          lat;
        va = mk(1, 0, 28'h0000008, 8'd10,  32'h80000200, 32'h80000200, 0, 1, 11, 10);
        vb = mk(1, 1, 28'h0000000, 8'd254, 32'hFF800000, 32'hFF800000, 1, 0, 4, 3);
        bus.out_ready = 1'b1;
        sb.push_back(expect_of(va));
        run_op(va, res, ovf, unf, lat);
        x = sb.pop_front();
        checks++; if (res !== x.result) $display("[TB] FAIL b2b_a RESULT: got %h want %h", res, x.result); else passes++;
        checks++; if (unf !== x.unf) $display("[TB] FAIL b2b_a UNF: got %b want %b", unf, x.unf); else passes++;
        drain();
        sb.push_back(expect_of(vb));
        run_op(vb, res, ovf, unf, lat);
        x = sb.pop_front();
        checks++; if (res !== x.result) $display("[TB] FAIL b2b_b RESULT: got %h want %h", res, x.result); else passes++;
        checks++; if (ovf !== x.ovf) $display("[TB] FAIL b2b_b OVF: got %b want %b", ovf, x.ovf); else passes++;
        checks++; if (lat !== x.lat) $display("[TB] FAIL b2b_b latency: got %0d want %0d", lat, x.lat); else passes++;
        drain();
        checks++; if (sb.size() !== 0) $display("[TB] FAIL scoreboard leftover: got %0d want 0", sb.size()); else passes++;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_reset_abort();
        test_backpressure();
        test_ignore_busy();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
